chip8_mem_arbiter: RTL and testbench

- Parametrised N-client arbiter and byte sequencer in front of one synchronous single-port byte-wide BRAM port.
- Each client issues multi-byte big-endian read or write requests. The block serialises them byte by byte with round-robin fairness, pipelines back-to-back requests, and returns assembled read words.
- Successor to the fixed proc/video/debug memory front end. Region offsets (RAM/VRAM/REG/STK) are applied by clients before the request.

---
 rtl/chip8_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: N-client byte sequencer and response assembler in front of one single-port byte BRAM.
// Define CHIP8_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module chip8_mem_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W = 13,
  parameter int MAX_BYTES = 2,
  parameter int LATENCY = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic [NUM_CLIENTS-1:0] req_valid_in,
  output logic [NUM_CLIENTS-1:0] req_ready_out,
  input  logic [NUM_CLIENTS-1:0] req_we_in,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_CLIENTS*2-1:0] req_size_in,
  input  logic [NUM_CLIENTS*MAX_BYTES*8-1:0] req_data_in,
  output logic [NUM_CLIENTS-1:0] resp_valid_out,
  output logic [MAX_BYTES*8-1:0] resp_data_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic mem_we_out,
  output logic [7:0] mem_data_out,
  input  logic [7:0] mem_data_in,
  output logic busy_out
);
  localparam int N = NUM_CLIENTS;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int DW = MAX_BYTES * 8;
  localparam logic [1:0] SZ_MAX = 2'(MAX_BYTES - 1);
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic v;
    logic [CW-1:0] cl;
    logic first;
    logic last;
    logic we;
  } tag_t;
  state_t st;
  logic [CW-1:0] cur, c, ptr;
  logic [1:0] k, kk, bi;
  logic [N-1:0] pend, occ;
  logic [CW:0] a1, a2;
  logic fire, last;
  logic [DW-1:0] acc, nacc;
  tag_t tg [LATENCY+1];
  logic we_s [N];
  logic [ADDR_W-1:0] addr_s [N];
  logic [1:0] sz_s [N];
  logic [DW-1:0] dat_s [N];
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction
  // {found, index}: first set bit of m searching upward from s, wrapping
  function automatic logic [CW:0] pick(input logic [N-1:0] m, input logic [CW-1:0] s);
    logic [CW:0] r;
    r = '0;
    for (int j = N - 1; j >= 0; j--) begin
      int t;
      t = (int'(s) + j) % N;
      if (m[CW'(t)]) r = {1'b1, CW'(t)};
    end
    return r;
  endfunction
`ifdef CHIP8_MEM_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
  assign ptr = '0;
`else
  localparam bit RR = 1'b1;
  always_ff @(posedge clk_in)
    if (!rst_n_in) ptr <= '0;
    else if (fire && last && a2[CW]) ptr <= inc(a2[CW-1:0]);
    else if (st == IDLE && a1[CW]) ptr <= inc(a1[CW-1:0]);
`endif
  assign req_ready_out = ~occ;
  // A grant from IDLE puts its first byte on the port in the same edge
  always_comb begin
    a1 = pick(pend, ptr);
    c = st == ISSUE ? cur : a1[CW-1:0];
    kk = st == ISSUE ? k : 2'd0;
    fire = st == ISSUE || a1[CW];
    last = kk == sz_s[c];
    bi = sz_s[c] - kk;
    a2 = pick(pend & ~(N'(1) << c), RR ? inc(c) : '0);
    nacc = (tg[LATENCY].first ? '0 : acc << 8) | DW'(mem_data_in);
    busy_out = |pend || st == ISSUE;
    for (int j = 0; j <= LATENCY; j++) busy_out = busy_out | tg[j].v;
  end
  always_ff @(posedge clk_in)
    for (int i = 0; i < N; i++)
      if (req_valid_in[i] && !occ[i]) begin
        we_s[i] <= req_we_in[i];
        addr_s[i] <= req_addr_in[i*ADDR_W +: ADDR_W];
        sz_s[i] <= req_size_in[2*i +: 2] > SZ_MAX ? SZ_MAX : req_size_in[2*i +: 2];
        dat_s[i] <= req_data_in[i*DW +: DW];
      end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      st <= IDLE;
      cur <= '0;
      k <= '0;
      pend <= '0;
      occ <= '0;
      acc <= '0;
      resp_valid_out <= '0;
      resp_data_out <= '0;
      mem_addr_out <= '0;
      mem_we_out <= 1'b0;
      mem_data_out <= '0;
      for (int j = 0; j <= LATENCY; j++) tg[j] <= '0;
    end else begin
      occ <= occ & ~resp_valid_out;
      if (fire && last) pend[c] <= 1'b0;
      for (int i = 0; i < N; i++)
        if (req_valid_in[i] && !occ[i]) begin
          occ[i] <= 1'b1;
          pend[i] <= 1'b1;
        end
      mem_we_out <= fire && we_s[c];
      if (fire) begin
        mem_addr_out <= addr_s[c] + ADDR_W'(kk);
        mem_data_out <= 8'(dat_s[c] >> {bi, 3'b000});
      end
      tg[0] <= '{v: fire, cl: c, first: kk == 2'd0, last: last, we: we_s[c]};
      for (int j = 1; j <= LATENCY; j++) tg[j] <= tg[j-1];
      resp_valid_out <= '0;
      if (tg[LATENCY].v) begin
        acc <= nacc;
        if (tg[LATENCY].last) begin
          resp_valid_out[tg[LATENCY].cl] <= 1'b1;
          resp_data_out <= tg[LATENCY].we ? '0 : nacc;
        end
      end
      if (fire) begin
        if (!last) begin
          st <= ISSUE;
          cur <= c;
          k <= kk + 2'd1;
        end else if (a2[CW]) begin
          st <= ISSUE;
          cur <= a2[CW-1:0];
          k <= '0;
        end else st <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: directed vectors plus timing sequences against a 2-cycle-latency BRAM model.
module tb_chip8_mem_arbiter;
  localparam int N = 3, AW = 13, MB = 2, LAT = 2, DW = MB * 8;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic [N-1:0] req_valid_in = '0, req_we_in = '0, req_ready_out, resp_valid_out;
  logic [N*AW-1:0] req_addr_in;
  logic [N*2-1:0] req_size_in;
  logic [N*DW-1:0] req_data_in;
  logic [DW-1:0] resp_data_out;
  logic [AW-1:0] mem_addr_out;
  logic mem_we_out, busy_out;
  logic [7:0] mem_data_out, mem_data_in;
  logic [AW-1:0] a_q [N];
  logic [1:0] s_q [N];
  logic [DW-1:0] d_q [N];
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] d1 = '0, d2 = '0;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    int c;
    logic we;
    logic [AW-1:0] a;
    logic [1:0] s;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt [12];
  always #5 clk_in = ~clk_in;
  always_comb
    for (int i = 0; i < N; i++) begin
      req_addr_in[i*AW +: AW] = a_q[i];
      req_size_in[2*i +: 2] = s_q[i];
      req_data_in[i*DW +: DW] = d_q[i];
    end
  assign mem_data_in = d2;
  always @(posedge clk_in) begin
    if (mem_we_out) mem[mem_addr_out] = mem_data_out;
    d1 <= mem[mem_addr_out];
    d2 <= d1;
  end
  chip8_mem_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .MAX_BYTES(MB), .LATENCY(LAT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_we_in(req_we_in), .req_addr_in(req_addr_in), .req_size_in(req_size_in), .req_data_in(req_data_in),
    .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out), .mem_addr_out(mem_addr_out),
    .mem_we_out(mem_we_out), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .busy_out(busy_out)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic set_req(input int c, input logic we, input logic [AW-1:0] a, input logic [1:0] s, input logic [DW-1:0] d);
    req_valid_in[c] = 1'b1;
    req_we_in[c] = we;
    a_q[c] = a;
    s_q[c] = s;
    d_q[c] = d;
  endtask
  task automatic wait_resp(input string nm, output logic [N-1:0] v, output logic [DW-1:0] d);
    for (int t = 0; t < 60 && resp_valid_out == '0; t++) tick();
    chk({nm, " seen"}, 32'(resp_valid_out != '0), 1);
    v = resp_valid_out;
    d = resp_data_out;
  endtask
  initial begin
    logic [N-1:0] v;
    logic [DW-1:0] d;
    int order[$];
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[13'h200] = 8'hA2; mem[13'h1FFF] = 8'h77; mem[13'h0000] = 8'h19;
    mem[13'h400] = 8'hC3; mem[13'h401] = 8'h5E; mem[13'h402] = 8'h99;
    for (int i = 0; i < N; i++) begin a_q[i] = '0; s_q[i] = '0; d_q[i] = '0; end
    vt[0]  = '{0, 1'b0, 13'h200,  2'd0, 16'h0000, 16'h00A2};
    vt[1]  = '{1, 1'b1, 13'h300,  2'd1, 16'h12AB, 16'h0000};
    vt[2]  = '{0, 1'b0, 13'h300,  2'd1, 16'h0000, 16'h12AB};
    vt[3]  = '{2, 1'b0, 13'h400,  2'd1, 16'h0000, 16'hC35E};
    vt[4]  = '{2, 1'b0, 13'h401,  2'd3, 16'h0000, 16'h5E99};
    vt[5]  = '{1, 1'b1, 13'h500,  2'd0, 16'h00EE, 16'h0000};
    vt[6]  = '{0, 1'b0, 13'h500,  2'd0, 16'h0000, 16'h00EE};
    vt[7]  = '{1, 1'b0, 13'h1FFF, 2'd1, 16'h0000, 16'h7719};
    vt[8]  = '{2, 1'b1, 13'h600,  2'd3, 16'hBEEF, 16'h0000};
    vt[9]  = '{0, 1'b0, 13'h600,  2'd1, 16'h0000, 16'hBEEF};
    vt[10] = '{1, 1'b1, 13'h602,  2'd0, 16'h1234, 16'h0000};
    vt[11] = '{2, 1'b0, 13'h601,  2'd1, 16'h0000, 16'hEF34};
    repeat (3) tick();
    rst_n_in = 1'b1;
    chk("rst ready", 32'(req_ready_out), 32'h7);
    chk("rst resp_valid", 32'(resp_valid_out), 0);
    chk("rst resp_data", 32'(resp_data_out), 0);
    chk("rst mem_addr", 32'(mem_addr_out), 0);
    chk("rst mem_we", 32'(mem_we_out), 0);
    chk("rst mem_data", 32'(mem_data_out), 0);
    chk("rst busy", 32'(busy_out), 0);
    // single 1-byte read: port at T+2, response at T+5, slot free at T+6
    set_req(0, 1'b0, 13'h200, 2'd0, 16'h0);
    tick(); req_valid_in[0] = 1'b0;
    chk("rd1 ready low", 32'(req_ready_out), 32'h6);
    chk("rd1 busy", 32'(busy_out), 1);
    tick();
    chk("rd1 addr T+2", 32'(mem_addr_out), 32'h200);
    chk("rd1 we T+2", 32'(mem_we_out), 0);
    tick(); tick();
    chk("rd1 no early resp", 32'(resp_valid_out), 0);
    tick();
    chk("rd1 resp T+5", 32'(resp_valid_out), 1);
    chk("rd1 data", 32'(resp_data_out), 32'h00A2);
    tick();
    chk("rd1 ready back", 32'(req_ready_out), 32'h7);
    // word write on client 1, read on client 0 accepted right after the write grant
    set_req(1, 1'b1, 13'h300, 2'd1, 16'h12AB);
    tick(); req_valid_in[1] = 1'b0;
    tick();
    chk("wr addr0", 32'(mem_addr_out), 32'h300);
    chk("wr data0", 32'(mem_data_out), 32'h12);
    chk("wr we0", 32'(mem_we_out), 1);
    set_req(0, 1'b0, 13'h300, 2'd1, 16'h0);
    tick(); req_valid_in[0] = 1'b0;
    chk("wr addr1", 32'(mem_addr_out), 32'h301);
    chk("wr data1", 32'(mem_data_out), 32'hAB);
    chk("wr we1", 32'(mem_we_out), 1);
    tick();
    chk("rd addr0 no bubble", 32'(mem_addr_out), 32'h300);
    chk("rd we0", 32'(mem_we_out), 0);
    tick();
    chk("rd addr1", 32'(mem_addr_out), 32'h301);
    tick();
    chk("wr resp", 32'(resp_valid_out), 32'h2);
    chk("wr resp data", 32'(resp_data_out), 0);
    tick();
    chk("gap resp", 32'(resp_valid_out), 0);
    tick();
    chk("rd resp", 32'(resp_valid_out), 32'h1);
    chk("rd resp data", 32'(resp_data_out), 32'h12AB);
    tick();
    // address wrap-around
    set_req(1, 1'b0, 13'h1FFF, 2'd1, 16'h0);
    tick(); req_valid_in[1] = 1'b0;
    tick();
    chk("wrap addr0", 32'(mem_addr_out), 32'h1FFF);
    tick();
    chk("wrap addr1", 32'(mem_addr_out), 32'h0000);
    tick(); tick(); tick();
    chk("wrap resp", 32'(resp_valid_out), 32'h2);
    chk("wrap data", 32'(resp_data_out), 32'h7719);
    tick();
    // arbitration mode: after a client-0 grant, clients 0 and 2 arrive together
    set_req(0, 1'b0, 13'h200, 2'd0, 16'h0);
    tick(); req_valid_in[0] = 1'b0;
    wait_resp("solo", v, d);
    tick();
    set_req(0, 1'b0, 13'h400, 2'd0, 16'h0);
    set_req(2, 1'b0, 13'h402, 2'd0, 16'h0);
    tick(); req_valid_in = '0;
    wait_resp("arb first", v, d);
`ifdef CHIP8_MEM_ARB_FIXED_PRIO_EN
    chk("arb first client", 32'(v), 32'h1);
    chk("arb first data", 32'(d), 32'h00C3);
`else
    chk("arb first client", 32'(v), 32'h4);
    chk("arb first data", 32'(d), 32'h0099);
`endif
    tick();
    wait_resp("arb second", v, d);
`ifdef CHIP8_MEM_ARB_FIXED_PRIO_EN
    chk("arb second client", 32'(v), 32'h4);
`else
    chk("arb second client", 32'(v), 32'h1);
`endif
    tick();
    // reset in the middle of a 2-byte read
    set_req(0, 1'b0, 13'h400, 2'd1, 16'h0);
    tick(); req_valid_in[0] = 1'b0;
    tick();
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    chk("mid rst ready", 32'(req_ready_out), 32'h7);
    chk("mid rst busy", 32'(busy_out), 0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk($sformatf("post rst resp %0d", t), 32'(resp_valid_out), 0);
      chk($sformatf("post rst we %0d", t), 32'(mem_we_out), 0);
    end
    // fairness: all clients hold 1-byte reads
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(13'h400 + i), 2'd0, 16'h0);
    for (int t = 0; t < 200 && order.size() < 6; t++) begin
      tick();
      if (resp_valid_out != '0) begin
        chk("fair onehot", 32'($countones(resp_valid_out)), 1);
        for (int i = 0; i < N; i++) if (resp_valid_out[i]) order.push_back(i);
      end
    end
    req_valid_in = '0;
    chk("fair count", 32'(order.size()), 6);
    for (int i = 0; i < order.size(); i++) chk($sformatf("fair grant %0d", i), 32'(order[i]), 32'(i % 3));
    for (int t = 0; t < 60 && (busy_out || req_ready_out != 3'b111); t++) tick();
    chk("drain ready", 32'(req_ready_out), 32'h7);
    chk("drain busy", 32'(busy_out), 0);
    // table-driven vectors
    foreach (vt[i]) begin
      set_req(vt[i].c, vt[i].we, vt[i].a, vt[i].s, vt[i].d);
      tick(); req_valid_in = '0;
      wait_resp($sformatf("vec%0d", i), v, d);
      chk($sformatf("vec%0d client", i), 32'(v), 32'(1 << vt[i].c));
      chk($sformatf("vec%0d data", i), 32'(d), 32'(vt[i].exp));
      tick();
    end
    chk("mem 600", 32'(mem[13'h600]), 32'hBE);
    chk("mem 601", 32'(mem[13'h601]), 32'hEF);
    chk("mem 602", 32'(mem[13'h602]), 32'h34);
    chk("end busy", 32'(busy_out), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
